// File: rtl/mem_port_arbiter.sv
// Fixed-priority (dbg > ls > if) arbiter for one single-ported memory with 1-cycle read latency.
// Grants are combinational; read responses are routed back one cycle later by a registered owner tag.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [XLEN-1:0]     if_rdata_o,

  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [XLEN-1:0]     ls_wdata_i,
  input  logic [XLEN/8-1:0]   ls_wstrb_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [XLEN-1:0]     ls_rdata_o,

  input  logic                dbg_req_i,
  input  logic [ADDR_W-1:0]   dbg_addr_i,
  output logic                dbg_gnt_o,
  output logic                dbg_rvalid_o,
  output logic [XLEN-1:0]     dbg_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  output logic [XLEN/8-1:0]   mem_wstrb_o,
  input  logic [XLEN-1:0]     mem_rdata_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS,
    OWN_DBG
  } owner_e;

  owner_e        rd_owner_q;
  logic [SW-1:0] starve_q;
  logic          force_if;

  assign force_if = if_req_i && (starve_q == STARVE_MAX);

  // A saturated fetch counter overrides even the debug port.
  always_comb begin
    if_gnt_o  = 1'b0;
    ls_gnt_o  = 1'b0;
    dbg_gnt_o = 1'b0;
    if (!rst_i) begin
      if (force_if)       if_gnt_o  = 1'b1;
      else if (dbg_req_i) dbg_gnt_o = 1'b1;
      else if (ls_req_i)  ls_gnt_o  = 1'b1;
      else if (if_req_i)  if_gnt_o  = 1'b1;
    end
  end

  always_comb begin
    mem_req_o   = if_gnt_o | ls_gnt_o | dbg_gnt_o;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (if_gnt_o) begin
      mem_addr_o  = if_addr_i;
    end else if (ls_gnt_o) begin
      mem_we_o    = ls_we_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
      mem_wstrb_o = ls_wstrb_i;
    end else if (dbg_gnt_o) begin
      mem_addr_o  = dbg_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_owner_q <= OWN_NONE;
      starve_q   <= '0;
    end else begin
      if (dbg_gnt_o)                 rd_owner_q <= OWN_DBG;
      else if (ls_gnt_o && !ls_we_i) rd_owner_q <= OWN_LS;
      else if (if_gnt_o)             rd_owner_q <= OWN_IF;
      else                           rd_owner_q <= OWN_NONE;

      if (if_req_i && !if_gnt_o) begin
        if (starve_q != STARVE_MAX) starve_q <= starve_q + SW'(1);
      end else begin
        starve_q <= '0;
      end
    end
  end

  // Gating by reset drops a response owed to a read granted just before reset.
  assign if_rvalid_o  = !rst_i && (rd_owner_q == OWN_IF);
  assign ls_rvalid_o  = !rst_i && (rd_owner_q == OWN_LS);
  assign dbg_rvalid_o = !rst_i && (rd_owner_q == OWN_DBG);

  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;
  assign dbg_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (STARVE_LIMIT 4 and 2) share stimulus and are
// checked every cycle against a transaction-level reference, plus directed tables/sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we, dbg_req;
  logic [31:0] if_addr, ls_addr, dbg_addr, ls_wdata;
  logic [3:0]  ls_wstrb;

  logic        if_gnt[2], ls_gnt[2], dbg_gnt[2];
  logic        if_rv[2], ls_rv[2], dbg_rv[2];
  logic [31:0] if_rd[2], ls_rd[2], dbg_rd[2];
  logic        mem_req[2], mem_we[2];
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2];
  logic [3:0]  mem_wstrb[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .STARVE_LIMIT(4)) u0 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(if_gnt[0]), .if_rvalid_o(if_rv[0]), .if_rdata_o(if_rd[0]),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata), .ls_wstrb_i(ls_wstrb),
    .ls_gnt_o(ls_gnt[0]), .ls_rvalid_o(ls_rv[0]), .ls_rdata_o(ls_rd[0]),
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr),
    .dbg_gnt_o(dbg_gnt[0]), .dbg_rvalid_o(dbg_rv[0]), .dbg_rdata_o(dbg_rd[0]),
    .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_wstrb_o(mem_wstrb[0]), .mem_rdata_i(mem_rdata[0])
  );

  mem_port_arbiter #(.XLEN(32), .ADDR_W(32), .STARVE_LIMIT(2)) u1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_gnt_o(if_gnt[1]), .if_rvalid_o(if_rv[1]), .if_rdata_o(if_rd[1]),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
    .ls_wdata_i(ls_wdata), .ls_wstrb_i(ls_wstrb),
    .ls_gnt_o(ls_gnt[1]), .ls_rvalid_o(ls_rv[1]), .ls_rdata_o(ls_rd[1]),
    .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr),
    .dbg_gnt_o(dbg_gnt[1]), .dbg_rvalid_o(dbg_rv[1]), .dbg_rdata_o(dbg_rd[1]),
    .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_wstrb_o(mem_wstrb[1]), .mem_rdata_i(mem_rdata[1])
  );

  // Memory contents are a fixed function of address; 0x10 holds a recognisable word.
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    mem_rdata[0] <= (mem_req[0] && !mem_we[0]) ? rd_of(mem_addr[0]) : 32'h0;
    mem_rdata[1] <= (mem_req[1] && !mem_we[1]) ? rd_of(mem_addr[1]) : 32'h0;
  end

  // Port ids: 0 none, 1 if, 2 ls, 3 dbg.
  int          m_wait[2]  = '{0, 0};
  int          m_pend[2]  = '{0, 0};
  int          m_gnt[2]   = '{0, 0};
  logic [31:0] m_paddr[2];
  logic [2:0]  cap_gnt[2], cap_rv[2];
  logic        cap_we0;
  logic [3:0]  cap_wstrb0;
  logic [31:0] cap_ls_rd0;
  int          cap_starve1;

  function automatic logic [2:0] onehot(input int p);
    return (p == 1) ? 3'b001 : (p == 2) ? 3'b010 : (p == 3) ? 3'b100 : 3'b000;
  endfunction

  function automatic logic [31:0] addr_of(input int p);
    return (p == 1) ? if_addr : (p == 2) ? ls_addr : (p == 3) ? dbg_addr : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_inst(input int k);
    int lim = (k == 0) ? 4 : 2;
    int g;
    logic [2:0] erv;
    if (rst)                          g = 0;
    else if (if_req && m_wait[k] == lim) g = 1;
    else if (dbg_req)                 g = 3;
    else if (ls_req)                  g = 2;
    else if (if_req)                  g = 1;
    else                              g = 0;
    m_gnt[k] = g;
    cap_gnt[k] = {dbg_gnt[k], ls_gnt[k], if_gnt[k]};
    cap_rv[k]  = {dbg_rv[k], ls_rv[k], if_rv[k]};
    chk($sformatf("gnt[%0d]", k), 64'(cap_gnt[k]), 64'(onehot(g)));
    chk($sformatf("mem_req[%0d]", k), 64'(mem_req[k]), 64'(g != 0));
    chk($sformatf("mem_addr[%0d]", k), 64'(mem_addr[k]), 64'(addr_of(g)));
    chk($sformatf("mem_we[%0d]", k), 64'(mem_we[k]), 64'(g == 2 && ls_we));
    chk($sformatf("mem_wdata[%0d]", k), 64'(mem_wdata[k]), 64'((g == 2) ? ls_wdata : 32'h0));
    chk($sformatf("mem_wstrb[%0d]", k), 64'(mem_wstrb[k]), 64'((g == 2) ? ls_wstrb : 4'h0));
    erv = rst ? 3'b000 : onehot(m_pend[k]);
    chk($sformatf("rvalid[%0d]", k), 64'(cap_rv[k]), 64'(erv));
    if (erv == 3'b001) chk($sformatf("if_rdata[%0d]", k), 64'(if_rd[k]), 64'(rd_of(m_paddr[k])));
    if (erv == 3'b010) chk($sformatf("ls_rdata[%0d]", k), 64'(ls_rd[k]), 64'(rd_of(m_paddr[k])));
    if (erv == 3'b100) chk($sformatf("dbg_rdata[%0d]", k), 64'(dbg_rd[k]), 64'(rd_of(m_paddr[k])));
  endtask

  task automatic update_inst(input int k);
    int lim = (k == 0) ? 4 : 2;
    if (rst) begin
      m_wait[k] = 0;
      m_pend[k] = 0;
    end else begin
      m_wait[k] = (if_req && m_gnt[k] != 1) ? ((m_wait[k] + 1 > lim) ? lim : m_wait[k] + 1) : 0;
      m_pend[k] = (m_gnt[k] == 2 && ls_we) ? 0 : m_gnt[k];
      m_paddr[k] = addr_of(m_gnt[k]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    cap_we0     = mem_we[0];
    cap_wstrb0  = mem_wstrb[0];
    cap_ls_rd0  = ls_rd[0];
    cap_starve1 = int'(u1.starve_q);
    @(posedge clk);
    update_inst(0);
    update_inst(1);
    #1;
  endtask

  task automatic drive(input logic r, input logic i, input logic l, input logic d, input logic w);
    rst = r; if_req = i; ls_req = l; dbg_req = d; ls_we = w;
  endtask

  typedef struct {
    logic       rst, ifr, lsr, dbgr, we;
    logic [2:0] gnt, rv;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int starve_exp[6];
    logic [2:0] pat[6];
    tbl[0]  = '{1, 1, 1, 1, 0, 3'b000, 3'b000};
    tbl[1]  = '{1, 1, 1, 1, 0, 3'b000, 3'b000};
    tbl[2]  = '{1, 1, 1, 1, 0, 3'b000, 3'b000};
    tbl[3]  = '{0, 1, 1, 1, 0, 3'b100, 3'b000};
    tbl[4]  = '{0, 1, 1, 1, 0, 3'b100, 3'b100};
    tbl[5]  = '{0, 1, 1, 1, 0, 3'b100, 3'b100};
    tbl[6]  = '{0, 1, 1, 1, 0, 3'b100, 3'b100};
    tbl[7]  = '{0, 1, 1, 1, 0, 3'b001, 3'b100};
    tbl[8]  = '{0, 1, 1, 1, 0, 3'b100, 3'b001};
    tbl[9]  = '{0, 1, 1, 1, 0, 3'b100, 3'b100};
    tbl[10] = '{0, 0, 1, 0, 1, 3'b010, 3'b100};
    tbl[11] = '{0, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[12] = '{0, 0, 1, 0, 0, 3'b010, 3'b000};
    tbl[13] = '{0, 1, 0, 0, 0, 3'b001, 3'b010};
    tbl[14] = '{1, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[15] = '{1, 0, 0, 0, 0, 3'b000, 3'b000};
    tbl[16] = '{0, 0, 0, 0, 0, 3'b000, 3'b000};

    if_addr = 32'h100; ls_addr = 32'h10; dbg_addr = 32'h200;
    ls_wdata = 32'h12345678; ls_wstrb = 4'h3;
    drive(1, 0, 0, 0, 0);
    #1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].ifr, tbl[i].lsr, tbl[i].dbgr, tbl[i].we);
      step();
      chk($sformatf("tbl%0d_gnt", i), 64'(cap_gnt[0]), 64'(tbl[i].gnt));
      chk($sformatf("tbl%0d_rv", i), 64'(cap_rv[0]), 64'(tbl[i].rv));
    end

    // Single read of 0x10.
    drive(0, 0, 1, 0, 0); ls_addr = 32'h10;
    step();
    chk("rd_gnt", 64'(cap_gnt[0]), 64'(3'b010));
    drive(0, 0, 0, 0, 0);
    step();
    chk("rd_rv", 64'(cap_rv[0]), 64'(3'b010));
    chk("rd_data", 64'(cap_ls_rd0), 64'(32'hDEADBEEF));

    // Write: strobes visible at grant, no response after.
    drive(0, 0, 1, 0, 1); ls_wstrb = 4'h3; ls_wdata = 32'h12345678;
    step();
    chk("wr_we", 64'(cap_we0), 64'(1'b1));
    chk("wr_strb", 64'(cap_wstrb0), 64'(4'h3));
    drive(0, 0, 0, 0, 0);
    step();
    chk("wr_no_rv", 64'(cap_rv[0]), 64'(3'b000));

    // Starvation with ls on the STARVE_LIMIT=2 instance.
    pat = '{3'b010, 3'b010, 3'b001, 3'b010, 3'b010, 3'b001};
    starve_exp = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 0, 0);
      step();
      chk($sformatf("stv%0d_gnt", i), 64'(cap_gnt[1]), 64'(pat[i]));
      chk($sformatf("stv%0d_cnt", i), 64'(cap_starve1), 64'(starve_exp[i]));
    end

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
      if_addr  = ($urandom_range(0, 7) == 0) ? 32'h10 : $urandom;
      ls_addr  = $urandom;
      dbg_addr = $urandom;
      ls_wdata = $urandom;
      ls_wstrb = 4'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
